maxpool_2x2: RTL and testbench
==============================

Name: maxpool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage between the convolution engine and the ReLU stage.
- Consumes one signed convolution result per accepted beat, in row-major order, over an IMG_H x IMG_W feature map.
- Emits one pooled maximum per 2x2 window to the ReLU stage's maxpool_out/valid_in inputs.
- Supports ready/valid backpressure on both sides.

Parameters:
- DATA_W, 23, signed sample width, shared with the conv and relu stages.
- IMG_W, 26, feature-map width in pixels; must be even (elaboration-time assertion).
- IMG_H, 26, feature-map height in rows; must be even (elaboration-time assertion).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  conv_out carries a valid sample
- conv_out  in  DATA_W  signed input sample
- maxpool_ready  out  1  block accepts a sample this cycle
- maxpool_out  out  DATA_W  signed pooled maximum
- valid_out  out  1  maxpool_out valid
- relu_ready  in  1  downstream accepts maxpool_out this cycle
- frame_done  out  1  asserted together with valid_out on the last window of a frame

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - valid_out=0, maxpool_out=0, frame_done=0.
  - col=0, row=0, horizontal register h_max=0.
  - Line-buffer contents are don't-care.
- Handshakes:
  - maxpool_ready = !valid_out || relu_ready (combinational). It is low during reset.
  - A sample is accepted when valid_in && maxpool_ready.
  - An output beat completes when valid_out && relu_ready.
  - While valid_out=1 and relu_ready=0, maxpool_out, valid_out and frame_done hold stable.
- On each accepted sample (c=col, r=row, x=conv_out):
  - r even, c even: h_max <= x.
  - r even, c odd: line_buf[c/2] <= max(h_max, x).
  - r odd, c even: h_max <= x.
  - r odd, c odd:
    - maxpool_out <= max(line_buf[c/2], h_max, x); valid_out <= 1.
    - frame_done <= (r==IMG_H-1 && c==IMG_W-1).
- Without a new window result, valid_out and frame_done clear on a completed output beat.
- A completed output beat and a window-producing acceptance in the same cycle load the new result with valid_out remaining 1, so the stage runs at full throughput.
- Latency: maxpool_out is valid on the clock edge after the 4th sample of a window is accepted.
- Counters:
  - col increments per accepted sample and wraps IMG_W-1 -> 0.
  - On col wrap, row increments and wraps IMG_H-1 -> 0, so the next frame starts with no idle cycle.
- Arithmetic:
  - All comparisons are signed DATA_W, with no widening or saturation. The output is the exact input value of the winner.
  - Ties select either operand; the value is identical.
- Gaps: valid_in=0 cycles change no state, and conv_out is ignored during them.
- Reset mid-frame discards the partial frame and any pending output. After reset, the next accepted sample is pixel (0,0).
- Output count per frame: (IMG_W/2)*(IMG_H/2) beats, exactly one carrying frame_done.

Decomposition:
- Shared package cnn_pkg holds:
  - localparam DATA_W = 23
  - typedef logic signed [DATA_W-1:0] sample_t
  - function smax(sample_t a, sample_t b)
- The relu and conv stages import the same package.
- One sub-module: maxpool_line_buf. It is a depth IMG_W/2 by DATA_W register array with one synchronous write port and one combinational read port, both indexed by col/2.
- Counters, h_max, output register and handshake logic stay in maxpool_2x2.

Test Plan (bench overrides IMG_W=4, IMG_H=4):
- Rows 1..4, 5..8, 9..12, 13..16 streamed back-to-back with relu_ready=1 -> outputs 6, 8, 14, 16. frame_done is set only with 16. Each output appears one cycle after the accepted 2nd-row odd sample.
- All-negative frame: -20,-3,-7,-9 / -5,-1,-8,-2 / then -100 everywhere -> outputs -1, -2, -100, -100. Confirms signed compare and no clipping.
- relu_ready held 0 for 5 cycles after the first output (6) -> maxpool_out=6 and valid_out=1 are stable. maxpool_ready=0 and no sample is lost. The remaining outputs 8, 14, 16 arrive in order after release.
- Stuttering input with valid_in toggling every other cycle and junk value 99 during gaps -> same outputs 6, 8, 14, 16, and 99 never appears.
- rst pulsed after 6 accepted samples, then a full frame of 1..16 -> valid_out=0 the cycle after rst, and outputs are exactly 6, 8, 14, 16.
- Two frames back-to-back, 1..16 then 16..1 -> 6, 8, 14, 16, then 16, 14, 8, 6 (second frame rows 16..13, 12..9, 8..5, 4..1). frame_done is pulsed twice.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the conv -> maxpool -> relu datapath.
// sample_t is the signed fixed-width sample carried between stages.
// smax returns the exact larger operand (signed compare, no widening).
package cnn_pkg;

  localparam int DATA_W = 23;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Signed maximum of two samples; on a tie either operand is the same value.
  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// Purpose: holds the horizontal pair maxima of the even row, one entry per window column.
// Latency: write lands on the next clk edge; read is combinational from the addressed entry.
// Backpressure: none; the owner only writes on an accepted even-row odd-column sample.
module maxpool_line_buf #(
  parameter int DATA_W = 23,
  parameter int DEPTH  = 13,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are don't-care after reset; every entry is rewritten on the even row before use.
  logic [DATA_W-1:0] mem [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/maxpool_2x2.sv
// Purpose: streaming 2x2 stride-2 signed max-pool over an IMG_H x IMG_W row-major feature map.
// Latency: pooled result valid on the edge after the 4th sample of a window is accepted.
// Backpressure: ready/valid both sides; input stalls only while an unaccepted result is held.
module maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] conv_out,
  output logic                     maxpool_ready,
  output logic signed [DATA_W-1:0] maxpool_out,
  output logic                     valid_out,
  input  logic                     relu_ready,
  output logic                     frame_done
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Geometry must tile exactly into 2x2 windows, and the sample type is shared package-wide.
  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $error("maxpool_2x2: IMG_W must be even and at least 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $error("maxpool_2x2: IMG_H must be even and at least 2");
  end
  if (DATA_W != cnn_pkg::DATA_W) begin : g_bad_data_w
    $error("maxpool_2x2: DATA_W must match cnn_pkg::DATA_W");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  sample_t       h_max;
  sample_t       x;
  sample_t       lb_rdata;
  sample_t       pair_max;
  sample_t       win_max;
  logic [AW-1:0] lb_addr;
  logic          accept;
  logic          lb_we;
  logic          win_done;
  logic          last_pix;

  // Ready whenever the output slot is empty or being drained this cycle; held off during reset.
  assign maxpool_ready = !rst && (!valid_out || relu_ready);
  assign accept        = valid_in && maxpool_ready;

  assign x        = sample_t'(conv_out);
  assign lb_addr  = AW'(col >> 1);
  assign pair_max = smax(h_max, x);
  assign win_max  = smax(lb_rdata, pair_max);
  assign lb_we    = accept && !row[0] && col[0];
  assign win_done = accept && row[0] && col[0];
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  maxpool_line_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .addr (lb_addr),
    .wdata(pair_max),
    .rdata(lb_rdata)
  );

  // Pixel position counters, horizontal pair register and the registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      h_max       <= '0;
      maxpool_out <= '0;
      valid_out   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // Drain first; a window completing in the same cycle overrides and keeps valid_out high.
      if (valid_out && relu_ready) begin
        valid_out  <= 1'b0;
        frame_done <= 1'b0;
      end

      if (accept) begin
        if (!col[0]) begin
          h_max <= x;
        end

        if (win_done) begin
          maxpool_out <= win_max;
          valid_out   <= 1'b1;
          frame_done  <= last_pix;
        end

        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2 on a 4x4 map: streaming, signed values, stalls, gaps, reset, back-to-back frames.
// Output beats are captured on the falling edge whenever valid_out && relu_ready.
// Expected values are hand-computed window maxima.
module tb_maxpool_2x2;

  localparam int DW = 23;

  logic                 clk;
  logic                 rst;
  logic                 valid_in;
  logic signed [DW-1:0] conv_out;
  logic                 maxpool_ready;
  logic signed [DW-1:0] maxpool_out;
  logic                 valid_out;
  logic                 relu_ready;
  logic                 frame_done;

  int pass_cnt;
  int total_cnt;

  int out_q[$];
  bit fd_q[$];

  maxpool_2x2 #(
    .DATA_W(DW),
    .IMG_W (4),
    .IMG_H (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .conv_out     (conv_out),
    .maxpool_ready(maxpool_ready),
    .maxpool_out  (maxpool_out),
    .valid_out    (valid_out),
    .relu_ready   (relu_ready),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed output beat.
  always @(negedge clk) begin
    if (!rst && valid_out && relu_ready) begin
      out_q.push_back(int'(maxpool_out));
      fd_q.push_back(frame_done);
    end
  end

  // Present samples in order; with gaps, one idle cycle carrying junk 99 follows each sample.
  task automatic send_stream(input int vals[$], input bit gaps);
    bit acc;
    int waited;
    foreach (vals[i]) begin
      valid_in = 1'b1;
      conv_out = DW'(vals[i]);
      acc      = 1'b0;
      waited   = 0;
      while (!acc && waited < 100) begin
        @(negedge clk);
        acc = maxpool_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!acc) begin
        total_cnt++;
        $display("FAIL accept_timeout: sample %0d not accepted after %0d cycles (required accept)", vals[i], waited);
        valid_in = 1'b0;
        return;
      end
      if (gaps) begin
        valid_in = 1'b0;
        conv_out = DW'(99);
        @(posedge clk);
        #1;
      end
    end
    valid_in = 1'b0;
    conv_out = DW'(99);
  endtask

  // Wait (bounded) for n beats, then idle a few cycles so extra beats would also show up.
  task automatic wait_outputs(input int n);
    int cyc;
    cyc = 0;
    while (out_q.size() < n && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    out_q.delete();
    fd_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    valid_in   = 1'b0;
    conv_out   = '0;
    relu_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out);
    else pass_cnt++;
    total_cnt++;
    if (maxpool_out !== '0) $display("FAIL reset_maxpool_out: got %0d want 0", maxpool_out);
    else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done);
    else pass_cnt++;
    total_cnt++;
    if (maxpool_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", maxpool_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (maxpool_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", maxpool_ready);
    else pass_cnt++;
    clear_q();
  endtask

  task automatic test_basic();
    int exp_o[4] = '{6, 8, 14, 16};
    bit exp_f[4] = '{0, 0, 0, 1};
    clear_q();
    relu_ready = 1'b1;
    send_stream('{1, 2, 3, 4, 5}, 1'b0);
    total_cnt++;
    if (valid_out !== 1'b0) $display("FAIL basic_no_early_out: valid_out=%b want 0", valid_out);
    else pass_cnt++;
    send_stream('{6}, 1'b0);
    total_cnt++;
    if (valid_out !== 1'b1 || maxpool_out !== DW'(6))
      $display("FAIL basic_latency: valid_out=%b out=%0d want 1/6", valid_out, maxpool_out);
    else pass_cnt++;
    send_stream('{7, 8, 9, 10, 11, 12, 13, 14, 15, 16}, 1'b0);
    wait_outputs(4);
    total_cnt++;
    if (out_q.size() != 4) $display("FAIL basic_count: got %0d want 4", out_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total_cnt++;
      if (out_q[i] !== exp_o[i] || fd_q[i] !== exp_f[i])
        $display("FAIL basic_out[%0d]: got %0d fd=%b want %0d fd=%b", i, out_q[i], fd_q[i], exp_o[i], exp_f[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_negative();
    int exp_o[4] = '{-1, -2, -100, -100};
    clear_q();
    send_stream('{-20, -3, -7, -9, -5, -1, -8, -2,
                  -100, -100, -100, -100, -100, -100, -100, -100}, 1'b0);
    wait_outputs(4);
    total_cnt++;
    if (out_q.size() != 4) $display("FAIL neg_count: got %0d want 4", out_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total_cnt++;
      if (out_q[i] !== exp_o[i] || fd_q[i] !== (i == 3))
        $display("FAIL neg_out[%0d]: got %0d fd=%b want %0d", i, out_q[i], fd_q[i], exp_o[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int exp_o[4] = '{6, 8, 14, 16};
    int cyc;
    clear_q();
    relu_ready = 1'b1;
    fork
      send_stream('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16}, 1'b0);
      begin
        cyc = 0;
        while (cyc < 100) begin
          @(posedge clk);
          #1;
          if (valid_out) break;
          cyc++;
        end
        relu_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          total_cnt++;
          if (valid_out !== 1'b1 || maxpool_out !== DW'(6))
            $display("FAIL stall_hold: valid_out=%b out=%0d want 1/6", valid_out, maxpool_out);
          else pass_cnt++;
          total_cnt++;
          if (maxpool_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", maxpool_ready);
          else pass_cnt++;
          @(posedge clk);
          #1;
        end
        relu_ready = 1'b1;
      end
    join
    wait_outputs(4);
    total_cnt++;
    if (out_q.size() != 4) $display("FAIL stall_count: got %0d want 4", out_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total_cnt++;
      if (out_q[i] !== exp_o[i]) $display("FAIL stall_out[%0d]: got %0d want %0d", i, out_q[i], exp_o[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stutter();
    int exp_o[4] = '{6, 8, 14, 16};
    clear_q();
    relu_ready = 1'b1;
    send_stream('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16}, 1'b1);
    wait_outputs(4);
    total_cnt++;
    if (out_q.size() != 4) $display("FAIL stutter_count: got %0d want 4", out_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total_cnt++;
      if (out_q[i] !== exp_o[i] || fd_q[i] !== (i == 3))
        $display("FAIL stutter_out[%0d]: got %0d fd=%b want %0d", i, out_q[i], fd_q[i], exp_o[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_midframe_reset();
    int exp_o[4] = '{6, 8, 14, 16};
    clear_q();
    relu_ready = 1'b1;
    send_stream('{1, 2, 3, 4, 5, 6}, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total_cnt++;
    if (valid_out !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", valid_out);
    else pass_cnt++;
    clear_q();
    send_stream('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16}, 1'b0);
    wait_outputs(4);
    total_cnt++;
    if (out_q.size() != 4) $display("FAIL rst_mid_count: got %0d want 4", out_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total_cnt++;
      if (out_q[i] !== exp_o[i] || fd_q[i] !== (i == 3))
        $display("FAIL rst_mid_out[%0d]: got %0d fd=%b want %0d", i, out_q[i], fd_q[i], exp_o[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int exp_o[8] = '{6, 8, 14, 16, 16, 14, 8, 6};
    int nfd;
    clear_q();
    relu_ready = 1'b1;
    send_stream('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16,
                  16, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1}, 1'b0);
    wait_outputs(8);
    total_cnt++;
    if (out_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", out_q.size());
    else pass_cnt++;
    nfd = 0;
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      if (fd_q[i]) nfd++;
      total_cnt++;
      if (out_q[i] !== exp_o[i] || fd_q[i] !== (i == 3 || i == 7))
        $display("FAIL b2b_out[%0d]: got %0d fd=%b want %0d", i, out_q[i], fd_q[i], exp_o[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (nfd != 2) $display("FAIL b2b_frame_done_count: got %0d want 2", nfd);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_stutter();
    do_reset();
    test_midframe_reset();
    do_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
